// File: rtl/fifo_uart_pkg.sv
// Shared types and line-level constants for the FIFO-fed UART transmitter.
// Holds the transmitter state enum and the serial line levels.
package fifo_uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        POP,
        LOAD,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    localparam logic TX_IDLE  = 1'b1;
    localparam logic TX_START = 1'b0;
    localparam logic TX_STOP  = 1'b1;

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period tick counter for the UART transmitter.
// Ports: clk, rst (sync, active high), restart (reload to 0), bit_done (last tick).
module uart_bit_timer #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic bit_done
);

    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0] LAST = TW'(CLKS_PER_BIT - 1);

    logic [TW-1:0] tick_q;

    assign bit_done = (tick_q == LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            tick_q <= '0;
        end else if (restart || bit_done) begin
            tick_q <= '0;
        end else begin
            tick_q <= tick_q + 1'b1;
        end
    end

endmodule

// File: rtl/fifo_uart_tx.sv
// FIFO drain stage: pops bytes and sends them as start/data/[parity]/stop frames.
// Ports: clk, rst, fifo_empty, fifo_dout -> fifo_rd_en, tx, busy (all registered).
// Optional even parity bit is compiled in with FIFO_UART_TX_PARITY_EN.
module fifo_uart_tx
    import fifo_uart_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    output logic                  fifo_rd_en,
    output logic                  tx,
    output logic                  busy
);

    localparam int BW = $clog2(DATA_WIDTH);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

`ifdef FIFO_UART_TX_PARITY_EN
    localparam tx_state_t AFTER_DATA = PARITY;
`else
    localparam tx_state_t AFTER_DATA = STOP;
`endif

    tx_state_t             state_q, state_d;
    logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
    logic [BW-1:0]         bcnt_q, bcnt_d;
    logic                  tx_d, rd_en_d, busy_d;
    logic                  bit_done;
    logic                  restart;

`ifdef FIFO_UART_TX_PARITY_EN
    logic par_q, par_d;
`endif

    // Any state change reloads the tick counter so every state starts at tick 0.
    assign restart = (state_d != state_q);

    uart_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .restart  (restart),
        .bit_done (bit_done)
    );

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        bcnt_d  = bcnt_q;
`ifdef FIFO_UART_TX_PARITY_EN
        par_d   = par_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (!fifo_empty) state_d = POP;
            end
            POP: begin
                state_d = LOAD;
            end
            LOAD: begin
                shreg_d = fifo_dout;
                bcnt_d  = '0;
`ifdef FIFO_UART_TX_PARITY_EN
                par_d   = ^fifo_dout;
`endif
                state_d = START;
            end
            START: begin
                if (bit_done) state_d = DATA;
            end
            DATA: begin
                if (bit_done) begin
                    shreg_d = shreg_q >> 1;
                    if (bcnt_q == LAST_BIT) begin
                        bcnt_d  = '0;
                        state_d = AFTER_DATA;
                    end else begin
                        bcnt_d = bcnt_q + 1'b1;
                    end
                end
            end
`ifdef FIFO_UART_TX_PARITY_EN
            PARITY: begin
                if (bit_done) state_d = STOP;
            end
`endif
            STOP: begin
                // Only other point where empty is looked at: chain or go idle.
                if (bit_done) state_d = fifo_empty ? IDLE : POP;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so they leave a flop.
    always_comb begin
        tx_d    = TX_IDLE;
        rd_en_d = (state_d == POP);
        busy_d  = (state_d != IDLE);
        unique case (state_d)
            START:   tx_d = TX_START;
            DATA:    tx_d = shreg_d[0];
`ifdef FIFO_UART_TX_PARITY_EN
            PARITY:  tx_d = par_q;
`endif
            STOP:    tx_d = TX_STOP;
            default: tx_d = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            shreg_q    <= '0;
            bcnt_q     <= '0;
            tx         <= TX_IDLE;
            fifo_rd_en <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            bcnt_q     <= bcnt_d;
            tx         <= tx_d;
            fifo_rd_en <= rd_en_d;
            busy       <= busy_d;
        end
    end

`ifdef FIFO_UART_TX_PARITY_EN
    always_ff @(posedge clk) begin
        if (rst) par_q <= 1'b0;
        else     par_q <= par_d;
    end
`endif

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Self-checking bench for fifo_uart_tx with a behavioural 4-deep FIFO source.
// Frames are decoded off the serial line and compared to expected words.
module tb_fifo_uart_tx;

    localparam int DW  = 8;
    localparam int CPB = 4;
`ifdef FIFO_UART_TX_PARITY_EN
    localparam int NB  = 11;
    localparam bit PAR = 1'b1;
`else
    localparam int NB  = 10;
    localparam bit PAR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          fifo_empty;
    logic [DW-1:0] fifo_dout = '0;
    logic          fifo_rd_en;
    logic          tx;
    logic          busy;

    logic          wr_en = 1'b0;
    logic [DW-1:0] din   = '0;
    logic [DW-1:0] mem [4];
    logic [1:0]    wp  = '0;
    logic [1:0]    rp  = '0;
    logic [2:0]    cnt = '0;
    logic          fifo_full;
    logic          rd_ok;
    logic          wr_ok;

    int tests   = 0;
    int fails   = 0;
    int rd_cnt  = 0;
    int bad_pop = 0;
    logic [DW-1:0] exp_q [$];

    typedef struct {
        logic [DW-1:0] data;
        logic          par;
    } vec_t;

    vec_t tv [5];

    always #5 clk = ~clk;

    fifo_uart_tx #(
        .DATA_WIDTH   (DW),
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .fifo_empty (fifo_empty),
        .fifo_dout  (fifo_dout),
        .fifo_rd_en (fifo_rd_en),
        .tx         (tx),
        .busy       (busy)
    );

    assign fifo_empty = (cnt == 3'd0);
    assign fifo_full  = (cnt == 3'd4);
    assign rd_ok      = fifo_rd_en && !fifo_empty;
    assign wr_ok      = wr_en && !fifo_full;

    always @(posedge clk) begin
        if (rd_ok) begin
            fifo_dout <= mem[rp];
            rp        <= rp + 2'd1;
        end
        if (wr_ok) begin
            mem[wp] <= din;
            wp      <= wp + 2'd1;
        end
        cnt <= cnt + {2'b0, wr_ok} - {2'b0, rd_ok};
    end

    always @(negedge clk) begin
        if (fifo_rd_en) rd_cnt++;
        if (fifo_rd_en && fifo_empty) bad_pop++;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [10:0] mk_frame(input logic [DW-1:0] d,
                                             input logic p);
        logic [10:0] f;
        f      = '0;
        f[8:1] = d;
        if (PAR) begin
            f[9]  = p;
            f[10] = 1'b1;
        end else begin
            f[9] = 1'b1;
        end
        return f;
    endfunction

    task automatic wr(input logic [DW-1:0] d);
        din   = d;
        wr_en = 1'b1;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic wait_start(output int n);
        n = 0;
        while (tx !== 1'b0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
    endtask

    // Called on the first negedge of the start bit; returns on the last stop cycle.
    task automatic sample_frame(output logic [10:0] f, output bit steady);
        f      = '0;
        steady = 1'b1;
        for (int b = 0; b < NB; b++) begin
            for (int t = 0; t < CPB; t++) begin
                if (b != 0 || t != 0) @(negedge clk);
                if (t == 0) f[b] = tx;
                else if (tx !== f[b]) steady = 1'b0;
            end
        end
    endtask

    task automatic rand_writer(input int num);
        logic [DW-1:0] d;
        int g;
        for (int i = 0; i < num; i++) begin
            repeat ($urandom_range(0, 60)) @(negedge clk);
            g = 0;
            while (fifo_full && g < 1000) begin
                @(negedge clk);
                g++;
            end
            d = DW'($urandom);
            exp_q.push_back(d);
            wr(d);
        end
    endtask

    task automatic rand_monitor(input int num);
        logic [10:0]   f;
        logic [DW-1:0] d;
        bit            st;
        int            n;
        for (int i = 0; i < num; i++) begin
            wait_start(n);
            if (n >= 3000) begin
                chk("rand_start_timeout", 32'(n), 32'd0);
                return;
            end
            sample_frame(f, st);
            if (exp_q.size() == 0) begin
                chk("rand_unexpected_frame", 32'(f), 32'd0);
            end else begin
                d = exp_q.pop_front();
                chk("rand_frame", 32'(f), 32'(mk_frame(d, ^d)));
                chk("rand_steady", 32'(st), 32'd1);
            end
        end
    endtask

    initial begin
        logic [10:0]   f;
        logic [DW-1:0] bb [4];
        bit            st;
        int            n, r0, txl, bh, bl;

        tv[0] = '{8'hA5, 1'b0};
        tv[1] = '{8'h07, 1'b1};
        tv[2] = '{8'h03, 1'b0};
        tv[3] = '{8'h80, 1'b1};
        tv[4] = '{8'h7E, 1'b0};
        bb[0] = 8'h00;
        bb[1] = 8'hFF;
        bb[2] = 8'h3C;
        bb[3] = 8'hC3;

        // reset and empty idle
        repeat (4) @(negedge clk);
        chk("rst_tx", 32'(tx), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rd_en", 32'(fifo_rd_en), 32'd0);
        rst = 1'b0;
        r0  = rd_cnt;
        txl = 0;
        bh  = 0;
        repeat (40) begin
            @(negedge clk);
            if (tx !== 1'b1) txl++;
            if (busy !== 1'b0) bh++;
        end
        chk("idle_tx_low", 32'(txl), 32'd0);
        chk("idle_busy", 32'(bh), 32'd0);
        chk("idle_rd_en", 32'(rd_cnt - r0), 32'd0);

        // single frames from the vector table
        for (int i = 0; i < 5; i++) begin
            r0 = rd_cnt;
            wr(tv[i].data);
            wait_start(n);
            chk("latency", 32'(n), 32'd3);
            sample_frame(f, st);
            chk("frame", 32'(f), 32'(mk_frame(tv[i].data, tv[i].par)));
            chk("steady", 32'(st), 32'd1);
            chk("busy_last", 32'(busy), 32'd1);
            @(negedge clk);
            chk("busy_fall", 32'(busy), 32'd0);
            chk("rd_pulses", 32'(rd_cnt - r0), 32'd1);
            repeat (3) @(negedge clk);
        end

        // full FIFO, back-to-back
        rst = 1'b1;
        for (int i = 0; i < 4; i++) wr(bb[i]);
        chk("fifo_full", 32'(fifo_full), 32'd1);
        r0  = rd_cnt;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wait_start(n);
            chk("b2b_gap", 32'(n), 32'd3);
            sample_frame(f, st);
            chk("b2b_frame", 32'(f), 32'(mk_frame(bb[i], ^bb[i])));
        end
        chk("b2b_busy_last", 32'(busy), 32'd1);
        @(negedge clk);
        chk("b2b_busy_fall", 32'(busy), 32'd0);
        repeat (10) @(negedge clk);
        chk("b2b_rd_pulses", 32'(rd_cnt - r0), 32'd4);
        chk("b2b_empty_pop", 32'(bad_pop), 32'd0);

        // reset during data bit 3
        wr(8'h55);
        wait_start(n);
        repeat (4 + 4 * 3 + 1) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_tx", 32'(tx), 32'd1);
        chk("midrst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        r0  = rd_cnt;
        txl = 0;
        repeat (40) begin
            @(negedge clk);
            if (tx !== 1'b1) txl++;
        end
        chk("midrst_rd_en", 32'(rd_cnt - r0), 32'd0);
        chk("midrst_tx_idle", 32'(txl), 32'd0);

        // write during stop bit chains straight into the next frame
        wr(8'h5A);
        wait_start(n);
        repeat (CPB * (NB - 1) + 1) @(negedge clk);
        chk("stop_empty", 32'(fifo_empty), 32'd1);
        wr(8'hE1);
        n  = 0;
        bl = 0;
        while (tx !== 1'b0 && n < 100) begin
            @(negedge clk);
            n++;
            if (busy !== 1'b1) bl++;
        end
        chk("stop_chain_gap", 32'(n), 32'd4);
        chk("stop_chain_busy", 32'(bl), 32'd0);
        sample_frame(f, st);
        chk("stop_chain_frame", 32'(f), 32'(mk_frame(8'hE1, ^8'hE1)));
        repeat (5) @(negedge clk);

        // randomized traffic against the scoreboard
        fork
            rand_writer(24);
            rand_monitor(24);
        join
        repeat (5) @(negedge clk);
        chk("rand_leftover", 32'(exp_q.size()), 32'd0);
        chk("no_empty_pop", 32'(bad_pop), 32'd0);
        chk("final_idle", 32'(busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
